m2_block_writeback: RTL and testbench

Write-back stage for Milestone 2. It drains one 8x8 block of post-IDCT samples from the block-local dual-port RAM, clips each sample to 8 bits and packs two pixels per 16-bit word. It writes the block as 32 SRAM words into the output Y plane (320 pixels = 160 words per row). It is the counterpart of the pre-IDCT block fetcher, with data moving from block RAM to SRAM.

---
 rtl/m2_block_writeback_if.sv | 28 ++
 rtl/m2_block_writeback.sv | 145 ++++++++++++++
 tb/tb_m2_block_writeback.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/m2_block_writeback_if.sv
// Bus bundle for the block write-back stage: start/status, block RAM read ports and SRAM write port.
// The slave modport is the write-back engine; the master side feeds start, block indices and RAM data.
interface m2_block_writeback_if;
    logic        start;
    logic [5:0]  block_col;
    logic [5:0]  block_row;
    logic [6:0]  ram_address_a;
    logic [6:0]  ram_address_b;
    logic [31:0] ram_read_data_a;
    logic [31:0] ram_read_data_b;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        done;

    modport master (
        output start, block_col, block_row, ram_read_data_a, ram_read_data_b,
        input  ram_address_a, ram_address_b, SRAM_address, SRAM_write_data,
               SRAM_we_n, busy, done
    );

    modport slave (
        input  start, block_col, block_row, ram_read_data_a, ram_read_data_b,
        output ram_address_a, ram_address_b, SRAM_address, SRAM_write_data,
               SRAM_we_n, busy, done
    );
endinterface

// File: rtl/m2_block_writeback.sv
// Drains one 8x8 block of post-IDCT samples from block RAM, clips to 8 bits and
// writes it as 32 packed pixel-pair words into the output Y plane in SRAM.
module m2_block_writeback #(
    parameter logic [17:0] OUT_OFFSET = 18'd0,
    parameter logic [17:0] ROW_WORDS  = 18'd160
) (
    input logic                  Clock,
    input logic                  reset,
    m2_block_writeback_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_WRITE, S_FINISH} state_e;

    state_e      state_q, state_d;
    logic [4:0]  word_q, word_d;
    logic [5:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [6:0]  ram_addr_a_q, ram_addr_a_d;
    logic [6:0]  ram_addr_b_q, ram_addr_b_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_data_q, sram_data_d;
    logic        we_n_q, we_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [5:0]  word_ahead;
    logic [17:0] line_idx;
    logic [17:0] word_addr;

    function automatic logic [7:0] clip8(input logic signed [31:0] s);
        if (s < 0)
            return 8'd0;
        else if (s > 32'sd255)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    // RAM addresses lead the SRAM word being written by two words (one RAM latency + one register).
    assign word_ahead = {1'b0, word_q} + 6'd2;
    assign line_idx   = {9'd0, row_q, 3'b000} + {15'd0, word_q[4:2]};
    assign word_addr  = OUT_OFFSET + line_idx * ROW_WORDS
                      + {10'd0, col_q, 2'b00} + {16'd0, word_q[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LEAD;
            S_LEAD:   state_d = S_WRITE;
            S_WRITE:  if (word_q == 5'd31) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: every _d takes its held value first, so no path through the case can infer a latch.
    always_comb begin
        word_d       = word_q;
        col_d        = col_q;
        row_d        = row_q;
        ram_addr_a_d = ram_addr_a_q;
        ram_addr_b_d = ram_addr_b_q;
        sram_addr_d  = sram_addr_q;
        sram_data_d  = sram_data_q;
        we_n_d       = we_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                we_n_d = 1'b1;
                word_d = 5'd0;
                if (bus.start) begin
                    col_d        = bus.block_col;
                    row_d        = bus.block_row;
                    ram_addr_a_d = 7'd0;
                    ram_addr_b_d = 7'd1;
                    busy_d       = 1'b1;
                end
            end
            S_LEAD: begin
                ram_addr_a_d = 7'd2;
                ram_addr_b_d = 7'd3;
                word_d       = 5'd0;
            end
            S_WRITE: begin
                sram_addr_d  = word_addr;
                sram_data_d  = {clip8(bus.ram_read_data_a), clip8(bus.ram_read_data_b)};
                we_n_d       = 1'b0;
                ram_addr_a_d = {word_ahead, 1'b0};
                ram_addr_b_d = {word_ahead, 1'b1};
                word_d       = word_q + 5'd1;
            end
            S_FINISH: begin
                we_n_d = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            word_q       <= 5'd0;
            col_q        <= 6'd0;
            row_q        <= 6'd0;
            ram_addr_a_q <= 7'd0;
            ram_addr_b_q <= 7'd0;
            sram_addr_q  <= OUT_OFFSET;
            sram_data_q  <= 16'd0;
            we_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            word_q       <= word_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ram_addr_a_q <= ram_addr_a_d;
            ram_addr_b_q <= ram_addr_b_d;
            sram_addr_q  <= sram_addr_d;
            sram_data_q  <= sram_data_d;
            we_n_q       <= we_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ram_address_a   = ram_addr_a_q;
    assign bus.ram_address_b   = ram_addr_b_q;
    assign bus.SRAM_address    = sram_addr_q;
    assign bus.SRAM_write_data = sram_data_q;
    assign bus.SRAM_we_n       = we_n_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_m2_block_writeback.sv
// Directed bench for the block write-back stage: timeline, addressing, clipping,
// start-while-busy and mid-block reset, against hand-derived expectations.
module tb_m2_block_writeback;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m2_block_writeback_if bus();

    m2_block_writeback #(.OUT_OFFSET(18'd0), .ROW_WORDS(18'd160)) dut (
        .Clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Synchronous dual-port block RAM model.
    logic signed [31:0] mem [0:63];
    always @(posedge clk) begin
        bus.ram_read_data_a <= mem[bus.ram_address_a[5:0]];
        bus.ram_read_data_b <= mem[bus.ram_address_b[5:0]];
    end

    int checks   = 0;
    int failures = 0;

    localparam int MAXE = 80;
    logic        obs_we   [MAXE];
    logic        obs_busy [MAXE];
    logic        obs_done [MAXE];
    logic [17:0] obs_addr [MAXE];
    logic [15:0] obs_data [MAXE];
    logic [6:0]  obs_ra   [MAXE];
    logic [6:0]  obs_rb   [MAXE];

    function automatic int exp_addr(input int col, input int row, input int w);
        return (row * 8 + (w >> 2)) * 160 + col * 4 + (w & 3);
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) mem[i] = i;
    endtask

    // Raise start before edge E0, then record outputs 1 time unit after edges E0..E(n-1).
    task automatic capture(input logic [5:0] col, input logic [5:0] row,
                           input bit hold, input int n_edges);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.block_col = col;
        bus.block_row = row;
        for (int n = 0; n < n_edges; n++) begin
            @(posedge clk);
            #1;
            obs_we[n]   = bus.SRAM_we_n;
            obs_busy[n] = bus.busy;
            obs_done[n] = bus.done;
            obs_addr[n] = bus.SRAM_address;
            obs_data[n] = bus.SRAM_write_data;
            obs_ra[n]   = bus.ram_address_a;
            obs_rb[n]   = bus.ram_address_b;
            if (n == 0 && !hold) begin
                bus.start     = 1'b0;
                bus.block_col = ~col;
                bus.block_row = ~row;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus.SRAM_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", bus.SRAM_we_n); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.SRAM_address !== 18'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.SRAM_address); end
        checks++; if (bus.SRAM_write_data !== 16'd0) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.SRAM_write_data); end
        checks++; if (bus.ram_address_a !== 7'd0) begin failures++; $display("FAIL reset_ram_a got=%0d exp=0", bus.ram_address_a); end
        checks++; if (bus.ram_address_b !== 7'd0) begin failures++; $display("FAIL reset_ram_b got=%0d exp=0", bus.ram_address_b); end
    endtask

    task automatic test_basic_block();
        int nd = 0;
        fill_ramp();
        capture(6'd0, 6'd0, 1'b0, 40);
        checks++; if (obs_ra[0] !== 7'd0 || obs_rb[0] !== 7'd1) begin failures++; $display("FAIL basic_ram_e0 got=%0d/%0d exp=0/1", obs_ra[0], obs_rb[0]); end
        checks++; if (obs_ra[1] !== 7'd2 || obs_rb[1] !== 7'd3) begin failures++; $display("FAIL basic_ram_e1 got=%0d/%0d exp=2/3", obs_ra[1], obs_rb[1]); end
        for (int n = 0; n < 40; n++) begin
            logic wexp;
            logic [15:0] dexp;
            wexp = (n >= 2 && n <= 33);
            checks++; if (obs_we[n] !== !wexp) begin failures++; $display("FAIL basic_we_n edge=%0d got=%b exp=%b", n, obs_we[n], !wexp); end
            checks++; if (obs_busy[n] !== (n <= 33)) begin failures++; $display("FAIL basic_busy edge=%0d got=%b exp=%b", n, obs_busy[n], (n <= 33)); end
            checks++; if (obs_done[n] !== (n == 34)) begin failures++; $display("FAIL basic_done edge=%0d got=%b exp=%b", n, obs_done[n], (n == 34)); end
            if (obs_done[n] === 1'b1) nd++;
            if (wexp) begin
                dexp = {8'(2 * (n - 2)), 8'(2 * (n - 2) + 1)};
                checks++; if (obs_addr[n] !== 18'(exp_addr(0, 0, n - 2))) begin failures++; $display("FAIL basic_addr word=%0d got=%0d exp=%0d", n - 2, obs_addr[n], exp_addr(0, 0, n - 2)); end
                checks++; if (obs_data[n] !== dexp) begin failures++; $display("FAIL basic_data word=%0d got=%h exp=%h", n - 2, obs_data[n], dexp); end
            end
        end
        checks++; if (obs_data[2] !== 16'h0001) begin failures++; $display("FAIL basic_first_data got=%h exp=0001", obs_data[2]); end
        checks++; if (obs_addr[33] !== 18'd1123 || obs_data[33] !== 16'h3E3F) begin failures++; $display("FAIL basic_last got=%0d/%h exp=1123/3e3f", obs_addr[33], obs_data[33]); end
        checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_clip();
        fill_ramp();
        mem[0] = -32'sd5;
        mem[1] = 32'sd300;
        mem[2] = 32'h7FFF_FFFF;
        mem[3] = 32'h8000_0000;
        mem[4] = 32'sd255;
        mem[5] = 32'sd0;
        mem[6] = 32'sd128;
        mem[7] = 32'sd256;
        capture(6'd2, 6'd1, 1'b0, 40);
        checks++; if (obs_addr[2] !== 18'd1288) begin failures++; $display("FAIL clip_addr got=%0d exp=1288", obs_addr[2]); end
        checks++; if (obs_data[2] !== 16'h00FF) begin failures++; $display("FAIL clip_neg_over got=%h exp=00ff", obs_data[2]); end
        checks++; if (obs_data[3] !== 16'hFF00) begin failures++; $display("FAIL clip_extremes got=%h exp=ff00", obs_data[3]); end
        checks++; if (obs_data[4] !== 16'hFF00) begin failures++; $display("FAIL clip_bounds got=%h exp=ff00", obs_data[4]); end
        checks++; if (obs_data[5] !== 16'h80FF) begin failures++; $display("FAIL clip_mid_256 got=%h exp=80ff", obs_data[5]); end
    endtask

    task automatic test_last_block();
        int nw = 0;
        fill_ramp();
        capture(6'd39, 6'd29, 1'b0, 40);
        for (int n = 0; n < 40; n++) begin
            logic wexp;
            wexp = (n >= 2 && n <= 33);
            checks++; if (obs_we[n] !== !wexp) begin failures++; $display("FAIL last_we_n edge=%0d got=%b exp=%b", n, obs_we[n], !wexp); end
            if (obs_we[n] === 1'b0) nw++;
            if (wexp) begin
                checks++; if (obs_addr[n] !== 18'(exp_addr(39, 29, n - 2))) begin failures++; $display("FAIL last_addr word=%0d got=%0d exp=%0d", n - 2, obs_addr[n], exp_addr(39, 29, n - 2)); end
            end
        end
        checks++; if (obs_addr[2] !== 18'd37276) begin failures++; $display("FAIL last_first_addr got=%0d exp=37276", obs_addr[2]); end
        checks++; if (obs_addr[33] !== 18'd38399) begin failures++; $display("FAIL last_final_addr got=%0d exp=38399", obs_addr[33]); end
        checks++; if (obs_data[33] !== 16'h3E3F) begin failures++; $display("FAIL last_final_data got=%h exp=3e3f", obs_data[33]); end
        checks++; if (nw != 32) begin failures++; $display("FAIL last_write_count got=%0d exp=32", nw); end
        checks++; if (obs_done[34] !== 1'b1) begin failures++; $display("FAIL last_done got=%b exp=1", obs_done[34]); end
    endtask

    task automatic test_start_hold();
        int nw = 0;
        int nd = 0;
        fill_ramp();
        capture(6'd5, 6'd2, 1'b1, 70);
        for (int n = 0; n < 70; n++) begin
            logic wexp;
            logic dexp;
            wexp = (n >= 2 && n <= 33) || (n >= 37 && n <= 68);
            dexp = (n == 34) || (n == 69);
            checks++; if (obs_we[n] !== !wexp) begin failures++; $display("FAIL hold_we_n edge=%0d got=%b exp=%b", n, obs_we[n], !wexp); end
            checks++; if (obs_done[n] !== dexp) begin failures++; $display("FAIL hold_done edge=%0d got=%b exp=%b", n, obs_done[n], dexp); end
            if (obs_we[n] === 1'b0) nw++;
            if (obs_done[n] === 1'b1) nd++;
        end
        checks++; if (obs_busy[34] !== 1'b0 || obs_busy[35] !== 1'b1) begin failures++; $display("FAIL hold_restart got=%b%b exp=01", obs_busy[34], obs_busy[35]); end
        checks++; if (obs_addr[37] !== 18'd2580) begin failures++; $display("FAIL hold_second_addr got=%0d exp=2580", obs_addr[37]); end
        checks++; if (nw != 64) begin failures++; $display("FAIL hold_write_count got=%0d exp=64", nw); end
        checks++; if (nd != 2) begin failures++; $display("FAIL hold_done_count got=%0d exp=2", nd); end
    endtask

    task automatic test_reset_abort();
        int nw = 0;
        int nd = 0;
        fill_ramp();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.block_col = 6'd1;
        bus.block_row = 6'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (bus.SRAM_we_n !== 1'b0 || bus.SRAM_address !== 18'd1606 || bus.SRAM_write_data !== 16'h1415) begin
            failures++; $display("FAIL abort_11th_write got=%b/%0d/%h exp=0/1606/1415", bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.SRAM_we_n !== 1'b1) begin failures++; $display("FAIL abort_we_n got=%b exp=1", bus.SRAM_we_n); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.SRAM_address !== 18'd0) begin failures++; $display("FAIL abort_addr got=%0d exp=0", bus.SRAM_address); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.SRAM_we_n === 1'b0) nw++;
            if (bus.done === 1'b1) nd++;
        end
        checks++; if (nw != 0) begin failures++; $display("FAIL abort_stray_writes got=%0d exp=0", nw); end
        checks++; if (nd != 0) begin failures++; $display("FAIL abort_stray_done got=%0d exp=0", nd); end
        nw = 0;
        nd = 0;
        capture(6'd1, 6'd1, 1'b0, 40);
        for (int n = 0; n < 40; n++) begin
            if (obs_we[n] === 1'b0) nw++;
            if (obs_done[n] === 1'b1) nd++;
        end
        checks++; if (nw != 32) begin failures++; $display("FAIL rerun_write_count got=%0d exp=32", nw); end
        checks++; if (nd != 1 || obs_done[34] !== 1'b1) begin failures++; $display("FAIL rerun_done got=%0d/%b exp=1/1", nd, obs_done[34]); end
        checks++; if (obs_addr[2] !== 18'd1284 || obs_data[2] !== 16'h0001) begin failures++; $display("FAIL rerun_first got=%0d/%h exp=1284/0001", obs_addr[2], obs_data[2]); end
        checks++; if (obs_addr[33] !== 18'd2407 || obs_data[33] !== 16'h3E3F) begin failures++; $display("FAIL rerun_last got=%0d/%h exp=2407/3e3f", obs_addr[33], obs_data[33]); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.block_col = 6'd0;
        bus.block_row = 6'd0;
        fill_ramp();
        test_reset();
        test_basic_block();
        test_clip();
        test_last_block();
        test_start_hold();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
